score_sequencer: RTL and testbench
==================================

# score_sequencer

Score sequencer feeding the buzzer tone stage. It walks a synchronous score ROM and holds each note code for its encoded number of beats. It inserts a short silent articulation gap between notes and signals end-of-song. Its `note_code` output drives the note-to-frequency lookup directly; 12'h000 means silence.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: `sys_clk` frequency.
- `BEAT_HZ`, 4: beat rate. `BEAT_CYCLES = CLK_HZ/BEAT_HZ`, which must be ≥ 2.
- `GAP_CYCLES`, 1_000_000: silent cycles after every score entry. 0 means no gap.
- `ADDR_W`, 8: score ROM address width.

Ports:
- `sys_clk`  in  1  the only clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `play`  in  1  level signal. 1 = run, 0 = pause (freeze in place).
- `restart`  in  1  one-cycle pulse: return to score address 0.
- `loop_en`  in  1  1 = restart automatically at the end marker.
- `rom_addr`  out  ADDR_W  score ROM address.
- `rom_data`  in  16  score word `{dur[3:0], high[3:0], med[3:0], low[3:0]}`. Valid one cycle after `rom_addr` changes.
- `note_code`  out  12  `{high, med, low}` of the sounding entry. 0 = silent.
- `note_valid`  out  1  1 while a non-zero code is sounding and the block is not paused.
- `busy`  out  1  1 in every state except IDLE.
- `done`  out  1  one-cycle pulse when the end marker is reached.

## Operation
- Score word 16'hFFFF is the end marker. Any entry with code 12'h000 is a rest (silent, but still timed).
- Entry duration is `(dur+1)*BEAT_CYCLES` unpaused cycles, i.e. 1–16 beats.
- States and transitions:
  - IDLE: goes to FETCH when `play`=1.
  - FETCH: 1 cycle while ROM data settles. Always goes to LATCH.
  - LATCH: captures `rom_data`.
    - If the word is FFFF, go to END.
    - Otherwise load `note_code` with code, `beats_left` with dur, clear `beat_cnt`, and go to PLAY.
  - PLAY: only cycles with `play`=1 advance `beat_cnt`.
    - When `beat_cnt == BEAT_CYCLES-1`, clear `beat_cnt`.
    - At that point, if `beats_left == 0`, clear `note_code` and go to GAP; otherwise decrement `beats_left`.
  - GAP: silent. `gap_cnt` advances only while `play`=1.
    - After GAP_CYCLES counted cycles, `rom_addr` increments and the state goes to FETCH.
    - With GAP_CYCLES=0, PLAY goes straight to the increment and FETCH.
  - END: `done`=1 for this single cycle and `rom_addr` is set to 0.
    - Next state is FETCH if `loop_en`=1, else IDLE.
- Pause (`play`=0 in FETCH, LATCH, PLAY or GAP):
  - All counters, `rom_addr` and the state hold.
  - `note_valid`=0, but `note_code` keeps its value internally.
  - Resuming continues with no lost or extra cycles.
- `restart`=1, from any state:
  - Next cycle: `rom_addr`=0, `note_code`=0, all counters cleared.
  - State goes to FETCH if `play`=1, else IDLE.
  - `restart` has priority over every other event, including END and tick-on-same-cycle.
- Address wrap: incrementing from `2^ADDR_W-1` wraps to 0 without a `done` pulse. This applies to a score with no end marker.
- `note_valid = (note_code != 0) & play & (state == PLAY)`.

## Timing
- Reset values: `rom_addr`=0, `note_code`=0, `note_valid`=0, `busy`=0, `done`=0, state IDLE. All internal counters are 0.
- Latency from `play` rising in IDLE to `note_code` valid: 3 edges (IDLE→FETCH, FETCH→LATCH, LATCH loads).
- `note_code` is registered and changes only on a LATCH entry, the PLAY→GAP transition, restart, or reset.
- Inter-note period equals the entry duration plus GAP_CYCLES plus 2 (FETCH and LATCH). `note_code` is 0 during the gap and during FETCH/LATCH.
- `done` is registered: high exactly one cycle, in END.
- `rst_n` asserted mid-note: all outputs return to reset values immediately (asynchronously). No residual tone.

## Test plan
Bench parameters: `CLK_HZ`=16, `BEAT_HZ`=4 (`BEAT_CYCLES`=4), `GAP_CYCLES`=2, `ADDR_W`=4.

- Reset:
  - Stimulus: assert `rst_n`=0 mid-PLAY.
  - Required response: `note_code`=0, `note_valid`=0, `busy`=0, `rom_addr`=0 before the next edge. After release, IDLE with `play`=0.
- Single note:
  - Stimulus: ROM[0]=16'h1015, ROM[1]=16'hFFFF, `loop_en`=0, `play`=1.
  - Required response: `note_code`=12'h015 and `note_valid`=1 for exactly 8 cycles, starting at the 3rd edge. Then silent for the gap plus FETCH/LATCH. Then one `done` pulse, then IDLE with `busy`=0 and `rom_addr`=0.
- Pause:
  - Stimulus: same score; drop `play` for 5 cycles after 3 sounding cycles.
  - Required response: `note_valid`=0 for those 5 cycles and `rom_addr` held. Total `note_valid` cycles is still 8.
- Rest and loop:
  - Stimulus: ROM[0]=16'h0000, ROM[1]=16'h0015, ROM[2]=16'hFFFF, `loop_en`=1.
  - Required response: `busy`=1 and `note_valid`=0 for 4 cycles (the rest), then 12'h015 for 4 cycles. `done` pulses once per pass and playback restarts at address 0 indefinitely.
- Restart:
  - Stimulus: pulse `restart` during PLAY at `rom_addr`=2.
  - Required response: next cycle `note_code`=0 and `rom_addr`=0. The ROM[0] code appears 2 edges later.
- Wrap:
  - Stimulus: all 16 entries 16'h0021, no end marker.
  - Required response: `rom_addr` runs 15→0, `done` never pulses, `note_code` stays 12'h021 during every PLAY.

Source files
------------

// File: rtl/score_sequencer.sv
// -----------------------------------------------------------------------------
// score_sequencer
//
// Walks a synchronous score ROM and plays it as a timed sequence of note codes
// for the buzzer tone stage. Each score word is {dur, high, med, low}. The
// 12-bit code {high, med, low} is held for (dur+1) beats. A silent
// articulation gap then follows before the next word is fetched. The word
// 16'hFFFF marks the end of the song, and a code of 12'h000 is a timed rest.
//
// Parameters
//   CLK_HZ     : sys_clk frequency in Hz
//   BEAT_HZ    : beat rate; CLK_HZ/BEAT_HZ must be at least 2
//   GAP_CYCLES : silent cycles after every entry (0 = no gap)
//   ADDR_W     : score ROM address width
//
// Ports
//   sys_clk    in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   play       in   1 = run, 0 = pause in place
//   restart    in   one-cycle pulse, jump back to address 0
//   loop_en    in   1 = replay from address 0 after the end marker
//   rom_addr   out  score ROM address
//   rom_data   in   score word, valid one cycle after rom_addr changes
//   note_code  out  code of the sounding entry, 0 = silent
//   note_valid out  a non-zero code is sounding and playback is not paused
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse when the end marker is reached
// -----------------------------------------------------------------------------
module score_sequencer #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BEAT_HZ    = 4,
  parameter int GAP_CYCLES = 1_000_000,
  parameter int ADDR_W     = 8
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              play,
  input  logic              restart,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [11:0]       note_code,
  output logic              note_valid,
  output logic              busy,
  output logic              done
);

  localparam int BEAT_CYCLES = CLK_HZ / BEAT_HZ;
  localparam int BEAT_W      = $clog2(BEAT_CYCLES);
  localparam int GAP_W       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PLAY,
    S_GAP,
    S_END
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic [11:0]         r_note_code;
  logic                r_done;
  logic [3:0]          r_beats_left;
  logic [BEAT_W-1:0]   r_beat_cnt;
  logic [GAP_W-1:0]    r_gap_cnt;

  logic                w_beat_end;
  logic                w_gap_end;
  logic                w_end_marker;

  assign w_beat_end   = (r_beat_cnt == BEAT_LAST);
  assign w_gap_end    = (r_gap_cnt == GAP_LAST);
  assign w_end_marker = (rom_data == 16'hFFFF);

  // NOTE: state registers use non-blocking assignments so every branch below
  // reads the values from before this edge, regardless of statement order.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rom_addr   <= '0;
      r_note_code  <= '0;
      r_done       <= 1'b0;
      r_beats_left <= '0;
      r_beat_cnt   <= '0;
      r_gap_cnt    <= '0;
    end else begin
      // done is high only for the single cycle spent in END.
      r_done <= 1'b0;

      if (restart) begin
        // Restart overrides every other event, including END and a beat
        // boundary that lands on the same cycle.
        r_rom_addr   <= '0;
        r_note_code  <= '0;
        r_beats_left <= '0;
        r_beat_cnt   <= '0;
        r_gap_cnt    <= '0;
        r_state      <= play ? S_FETCH : S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (play) r_state <= S_FETCH;
          end

          // One cycle for the synchronous ROM to present the word at rom_addr.
          S_FETCH: begin
            if (play) r_state <= S_LATCH;
          end

          S_LATCH: begin
            if (play) begin
              if (w_end_marker) begin
                r_done  <= 1'b1;
                r_state <= S_END;
              end else begin
                r_note_code  <= rom_data[11:0];
                r_beats_left <= rom_data[15:12];
                r_beat_cnt   <= '0;
                r_state      <= S_PLAY;
              end
            end
          end

          // beats_left counts the beats still owed after the current one, so
          // a dur of N sounds for N+1 full beats.
          S_PLAY: begin
            if (play) begin
              if (w_beat_end) begin
                r_beat_cnt <= '0;
                if (r_beats_left == 4'd0) begin
                  r_note_code <= '0;
                  if (GAP_CYCLES == 0) begin
                    r_rom_addr <= r_rom_addr + 1'b1;
                    r_state    <= S_FETCH;
                  end else begin
                    r_gap_cnt <= '0;
                    r_state   <= S_GAP;
                  end
                end else begin
                  r_beats_left <= r_beats_left - 1'b1;
                end
              end else begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
              end
            end
          end

          // The address increment wraps naturally, so a score without an end
          // marker simply repeats from address 0 with no done pulse.
          S_GAP: begin
            if (play) begin
              if (w_gap_end) begin
                r_gap_cnt  <= '0;
                r_rom_addr <= r_rom_addr + 1'b1;
                r_state    <= S_FETCH;
              end else begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
              end
            end
          end

          // END is not subject to pause: it always lasts exactly one cycle.
          S_END: begin
            r_rom_addr <= '0;
            r_state    <= loop_en ? S_FETCH : S_IDLE;
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rom_addr   = r_rom_addr;
  assign note_code  = r_note_code;
  assign done       = r_done;
  assign busy       = (r_state != S_IDLE);
  // Gating with the live play input silences the tone during a pause in the
  // same cycle, while note_code keeps the held value for the resume.
  assign note_valid = (r_note_code != 12'h000) && play && (r_state == S_PLAY);

endmodule

// File: tb/tb_score_sequencer.sv
// -----------------------------------------------------------------------------
// tb_score_sequencer
//
// Bench for score_sequencer with CLK_HZ=16, BEAT_HZ=4 (4-cycle beats),
// GAP_CYCLES=2 and ADDR_W=4. A synchronous ROM model feeds rom_data. Each
// scenario pushes its hand-computed per-cycle trace
// {note_code, note_valid, done, rom_addr} into a queue. The monitor pops one
// entry for every cycle the DUT is busy and compares it with the outputs.
// -----------------------------------------------------------------------------
module tb_score_sequencer;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        play;
  logic        restart;
  logic        loop_en;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic [11:0] note_code;
  logic        note_valid;
  logic        busy;
  logic        done;

  always #5 sys_clk = ~sys_clk;

  score_sequencer #(
    .CLK_HZ    (16),
    .BEAT_HZ   (4),
    .GAP_CYCLES(2),
    .ADDR_W    (4)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .play      (play),
    .restart   (restart),
    .loop_en   (loop_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note_code (note_code),
    .note_valid(note_valid),
    .busy      (busy),
    .done      (done)
  );

  // Synchronous score ROM: data follows the address by one edge.
  logic [15:0] rom [16];
  always @(posedge sys_clk) rom_data <= rom[rom_addr];

  typedef struct packed {
    logic [11:0] code;
    logic        valid;
    logic        dn;
    logic [3:0]  addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   n_samples = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Monitor: one trace entry per busy cycle, sampled on the falling edge.
  always @(negedge sys_clk) begin
    if (rst_n === 1'b1 && (busy === 1'b1 || done === 1'b1)) begin
      n_samples++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output[%0d]: got code=%h valid=%b done=%b addr=%h, expected no activity",
                 n_samples, note_code, note_valid, done, rom_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("trace[%0d] {code,valid,done,addr}", n_samples),
              32'({note_code, note_valid, done, rom_addr}),
              32'({mon_e.code, mon_e.valid, mon_e.dn, mon_e.addr}));
      end
    end
  end

  task automatic push(input logic [11:0] code, input logic valid, input logic dn,
                      input logic [3:0] addr, input int n);
    exp_t e;
    e.code  = code;
    e.valid = valid;
    e.dn    = dn;
    e.addr  = addr;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // FETCH + LATCH, the sounding cycles, then the 2-cycle gap.
  task automatic push_entry(input logic [11:0] code, input int cycles, input logic [3:0] addr);
    push(12'h000, 1'b0, 1'b0, addr, 2);
    push(code, code != 12'h000, 1'b0, addr, cycles);
    push(12'h000, 1'b0, 1'b0, addr, 2);
  endtask

  // FETCH + LATCH of the end marker, then the END cycle with done.
  task automatic push_end(input logic [3:0] addr);
    push(12'h000, 1'b0, 1'b0, addr, 2);
    push(12'h000, 1'b0, 1'b1, addr, 1);
  endtask

  task automatic clear_rom(input logic [15:0] fill);
    for (int i = 0; i < 16; i++) rom[i] = fill;
  endtask

  task automatic wait_done(input string name, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge sys_clk);
      #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(negedge sys_clk);
    check({name, "_trace_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_idle(input string name);
    @(negedge sys_clk);
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
    check({name, "_idle_addr"}, 32'(rom_addr), 32'd0);
    check({name, "_idle_code"}, 32'(note_code), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    play    = 1'b0;
    restart = 1'b0;
    loop_en = 1'b0;
    clear_rom(16'h0000);

    // ---- reset state ----
    repeat (2) @(posedge sys_clk);
    #2;
    check("rst_code",  32'(note_code),  32'd0);
    check("rst_valid", 32'(note_valid), 32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_done",  32'(done),       32'd0);
    check("rst_addr",  32'(rom_addr),   32'd0);
    @(posedge sys_clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("idle_hold_busy", 32'(busy), 32'd0);

    // ---- single note: 8 sounding cycles, gap, end marker ----
    clear_rom(16'h0000);
    rom[0] = 16'h1015;
    rom[1] = 16'hFFFF;
    push_entry(12'h015, 8, 4'd0);
    push_end(4'd1);
    @(posedge sys_clk);
    #1 play = 1'b1;
    wait_done("single", 40);
    play = 1'b0;
    drain("single");
    check_idle("single");

    // ---- pause: 3 sounding, 5 paused, 5 sounding ----
    push(12'h000, 1'b0, 1'b0, 4'd0, 2);
    push(12'h015, 1'b1, 1'b0, 4'd0, 3);
    push(12'h015, 1'b0, 1'b0, 4'd0, 5);
    push(12'h015, 1'b1, 1'b0, 4'd0, 5);
    push(12'h000, 1'b0, 1'b0, 4'd0, 2);
    push_end(4'd1);
    @(posedge sys_clk);
    #1 play = 1'b1;
    repeat (6) @(posedge sys_clk);
    #1 play = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1 play = 1'b1;
    wait_done("pause", 40);
    play = 1'b0;
    drain("pause");
    check_idle("pause");

    // ---- rest and loop: two full passes ----
    clear_rom(16'h0000);
    rom[0] = 16'h0000;
    rom[1] = 16'h0015;
    rom[2] = 16'hFFFF;
    for (int p = 0; p < 2; p++) begin
      push_entry(12'h000, 4, 4'd0);
      push_entry(12'h015, 4, 4'd1);
      push_end(4'd2);
    end
    @(posedge sys_clk);
    #1 loop_en = 1'b1;
    play = 1'b1;
    wait_done("loop_pass1", 40);
    wait_done("loop_pass2", 40);
    loop_en = 1'b0;
    play    = 1'b0;
    drain("loop");
    check_idle("loop");

    // ---- restart during PLAY at address 2 ----
    clear_rom(16'h0000);
    rom[0] = 16'h0011;
    rom[1] = 16'h0022;
    rom[2] = 16'h1033;
    rom[3] = 16'hFFFF;
    push_entry(12'h011, 4, 4'd0);
    push_entry(12'h022, 4, 4'd1);
    push(12'h000, 1'b0, 1'b0, 4'd2, 2);
    push(12'h033, 1'b1, 1'b0, 4'd2, 2);
    push_entry(12'h011, 4, 4'd0);
    push_entry(12'h022, 4, 4'd1);
    push_entry(12'h033, 8, 4'd2);
    push_end(4'd3);
    @(posedge sys_clk);
    #1 play = 1'b1;
    repeat (20) @(posedge sys_clk);
    #1 restart = 1'b1;
    @(posedge sys_clk);
    #1 restart = 1'b0;
    wait_done("restart", 60);
    play = 1'b0;
    drain("restart");
    check_idle("restart");

    // ---- address wrap: no end marker, 17 entries, then stop ----
    clear_rom(16'h0021);
    for (int a = 0; a < 17; a++) push_entry(12'h021, 4, 4'(a));
    @(posedge sys_clk);
    #1 play = 1'b1;
    repeat (136) @(posedge sys_clk);
    #1 play = 1'b0;
    restart = 1'b1;
    @(posedge sys_clk);
    #1 restart = 1'b0;
    drain("wrap");
    check_idle("wrap");

    // ---- asynchronous reset mid-PLAY at address 1 ----
    clear_rom(16'h0000);
    rom[0] = 16'h0011;
    rom[1] = 16'h0022;
    rom[2] = 16'hFFFF;
    push_entry(12'h011, 4, 4'd0);
    push(12'h000, 1'b0, 1'b0, 4'd1, 2);
    push(12'h022, 1'b1, 1'b0, 4'd1, 2);
    @(posedge sys_clk);
    #1 play = 1'b1;
    repeat (13) @(posedge sys_clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_code",  32'(note_code),  32'd0);
    check("midrst_valid", 32'(note_valid), 32'd0);
    check("midrst_busy",  32'(busy),       32'd0);
    check("midrst_addr",  32'(rom_addr),   32'd0);
    play = 1'b0;
    drain("midrst");
    @(posedge sys_clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("midrst_release_busy", 32'(busy),     32'd0);
    check("midrst_release_addr", 32'(rom_addr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
